// File: rtl/vid_fetch_if.sv
// SDRAM burst-read port of the video fetcher.
// The fetcher drives the master side; the memory controller the slave side.
interface vid_fetch_if #(
    parameter int ADDR_W = 24
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        input  mem_rvalid
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        output mem_rvalid
    );
endinterface

// File: rtl/vid_fetch.sv
// Framebuffer fetcher: SDRAM read bursts into a show-ahead word FIFO,
// one 32-bit word (two pixels) popped per req, restarted on vsync.
module vid_fetch #(
    parameter int ADDR_W      = 24,
    parameter int FRAME_WORDS = 153600,
    parameter int BURST_LEN   = 8,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ce,
    input  logic [ADDR_W-1:0]             fb_base,
    input  logic                          vsync,
    input  logic                          req,
    output logic [31:0]                   viddata,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    vid_fetch_if.master                   mem
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(FRAME_WORDS + 1);
    localparam int BW = $clog2(BURST_LEN) + 1;

    localparam logic [LW-1:0]     LMAX  = LW'(FIFO_DEPTH - BURST_LEN);
    localparam logic [CW-1:0]     FW    = CW'(FRAME_WORDS);
    localparam logic [CW-1:0]     CBL   = CW'(BURST_LEN);
    localparam logic [BW-1:0]     BLAST = BW'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] ABL   = ADDR_W'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state, nstate;

    logic              vsync_q;
    logic              fstart;
    logic              armed;
    logic              stale;
    logic              push;
    logic              pop;
    logic              last;
    logic              go;
    logic              acked;
    logic [ADDR_W-1:0] addr_ptr;
    logic [CW-1:0]     wcnt;
    logic [BW-1:0]     beat;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [31:0]       fifo [FIFO_DEPTH];

    assign fstart = ce & vsync & ~vsync_q;
    assign acked  = (state == REQ) & mem.mem_ack;
    assign push   = (state == DATA) & mem.mem_rvalid & ~fstart;
    assign pop    = ce & req & (fifo_level != '0);
    assign last   = mem.mem_rvalid & (beat == BLAST);
    // The IDLE decision must not use the pointer being reloaded this cycle
    assign go     = armed & ~fstart & (wcnt < FW) & (fifo_level <= LMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
        end else if (ce) begin
            vsync_q <= vsync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:  if (go) nstate = REQ;
            REQ:   if (mem.mem_ack) nstate = (stale | fstart) ? DRAIN : DATA;
            DATA:  if (last) nstate = IDLE;
                   else if (fstart) nstate = DRAIN;
            DRAIN: if (last) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        mem.mem_req = (state == REQ);
    end

    // A burst acked after a frame restart belongs to the old frame and
    // must not advance the freshly loaded pointer or word count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_ptr     <= '0;
            wcnt         <= '0;
            armed        <= 1'b0;
            stale        <= 1'b0;
            beat         <= '0;
            mem.mem_addr <= '0;
        end else begin
            if (fstart) begin
                addr_ptr <= fb_base;
                wcnt     <= '0;
                armed    <= 1'b1;
            end else if (acked & ~stale) begin
                addr_ptr <= addr_ptr + ABL;
                wcnt     <= wcnt + CBL;
            end
            if (state == REQ && !mem.mem_ack) begin
                stale <= stale | fstart;
            end else begin
                stale <= 1'b0;
            end
            if (state == IDLE && go) begin
                mem.mem_addr <= addr_ptr;
            end
            if (acked) begin
                beat <= '0;
            end else if ((state == DATA || state == DRAIN) && mem.mem_rvalid) begin
                beat <= beat + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            underrun   <= 1'b0;
        end else begin
            if (ce & req & (fifo_level == '0)) begin
                underrun <= 1'b1;
            end
            if (fstart) begin
                wptr       <= '0;
                rptr       <= '0;
                fifo_level <= '0;
            end else begin
                if (push) wptr <= wptr + AW'(1);
                if (pop)  rptr <= rptr + AW'(1);
                unique case ({push, pop})
                    2'b10:   fifo_level <= fifo_level + LW'(1);
                    2'b01:   fifo_level <= fifo_level - LW'(1);
                    default: fifo_level <= fifo_level;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wptr] <= mem.mem_rdata;
    end

    assign viddata = (fifo_level != '0) ? fifo[rptr] : 32'h0;

endmodule

// File: tb/tb_vid_fetch.sv
// Self-checking bench for vid_fetch: vector table for the pop/push basics,
// scoreboarded memory model for throttling, full frame and restart cases.
module tb_vid_fetch;

    localparam int AW = 24;
    localparam int FW = 1280;
    localparam int BL = 8;
    localparam int FD = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic [AW-1:0] fb_base;
    logic          vsync;
    logic          req;
    logic [31:0]   viddata;
    logic          underrun;
    logic [6:0]    fifo_level;

    vid_fetch_if #(.ADDR_W(AW)) mem ();

    vid_fetch #(
        .ADDR_W(AW),
        .FRAME_WORDS(FW),
        .BURST_LEN(BL),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ce(ce),
        .fb_base(fb_base),
        .vsync(vsync),
        .req(req),
        .viddata(viddata),
        .underrun(underrun),
        .fifo_level(fifo_level),
        .mem(mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ce, vs, ack, rv, rq;
        logic [31:0] rd;
        int          lvl;
        logic [31:0] vd;
        logic        mr;
        logic [23:0] ma;
        logic        ur;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          mem_auto;
    bit          sb_on;
    int          beats_left;
    int          nbursts;
    logic [31:0] dat;
    logic [23:0] exp_addr;
    logic [23:0] last_addr;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic c, v, a, r, input logic [31:0] d,
                                input logic q, input int l,
                                input logic [31:0] e, input logic m,
                                input logic [23:0] ad, input logic u);
        vec_t t;
        t.ce = c; t.vs = v; t.ack = a; t.rv = r; t.rd = d; t.rq = q;
        t.lvl = l; t.vd = e; t.mr = m; t.ma = ad; t.ur = u;
        tbl.push_back(t);
    endfunction

    // Memory model reacts to outputs seen at this negedge, then one cycle passes
    task automatic cyc();
        if (mem_auto) begin
            mem.mem_ack    = 1'b0;
            mem.mem_rvalid = 1'b0;
            if (beats_left > 0) begin
                mem.mem_rvalid = 1'b1;
                mem.mem_rdata  = dat;
                if (sb_on) sb.push_back(dat);
                dat++;
                beats_left--;
            end else if (mem.mem_req) begin
                mem.mem_ack = 1'b1;
                beats_left  = BL;
                nbursts++;
                check("burst_addr", mem.mem_addr, exp_addr);
                last_addr = mem.mem_addr;
                exp_addr  = exp_addr + 24'(BL);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ce = 1'b1; vsync = 1'b0; req = 1'b0; fb_base = '0;
        mem.mem_ack = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
        mem_auto = 0; sb_on = 0; beats_left = 0; nbursts = 0; dat = '0;
        sb.delete();
        @(negedge clk);
        check("rst_level", fifo_level, 0);
        check("rst_memreq", mem.mem_req, 0);
        check("rst_memaddr", mem.mem_addr, 0);
        check("rst_viddata", viddata, 0);
        check("rst_underrun", underrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1; cyc();
        vsync = 1'b0; cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int popped;
        int k;

        // Basic burst, pops, ce gating, push+pop at level 5, empty pop
        add(0,1,0,0,0,0, 0,0,0,24'h0,0);
        add(1,1,0,0,0,0, 0,0,0,24'h0,0);
        add(1,1,0,0,0,0, 0,0,1,24'h1000,0);
        add(1,0,0,0,0,0, 0,0,1,24'h1000,0);
        add(1,0,1,0,0,0, 0,0,0,24'h1000,0);
        for (int i = 0; i < 8; i++)
            add(1,0,0,1,32'(i),0, i+1,0,0,24'h1000,0);
        add(1,0,0,0,0,0, 8,0,1,24'h1008,0);
        add(0,0,0,0,0,1, 8,0,1,24'h1008,0);
        add(1,0,0,0,0,1, 7,1,1,24'h1008,0);
        add(1,0,0,0,0,1, 6,2,1,24'h1008,0);
        add(1,0,1,0,0,1, 5,3,0,24'h1008,0);
        add(1,0,0,1,100,1, 5,4,0,24'h1008,0);
        add(1,0,0,1,101,0, 6,4,0,24'h1008,0);
        add(1,0,0,0,0,1, 5,5,0,24'h1008,0);
        add(1,0,0,0,0,1, 4,6,0,24'h1008,0);
        add(1,0,0,0,0,1, 3,7,0,24'h1008,0);
        add(1,0,0,0,0,1, 2,100,0,24'h1008,0);
        add(1,0,0,0,0,1, 1,101,0,24'h1008,0);
        add(1,0,0,0,0,1, 0,0,0,24'h1008,0);
        add(1,0,0,0,0,1, 0,0,0,24'h1008,1);
        for (int i = 0; i < 6; i++)
            add(1,0,0,1,32'(102+i),0, i+1,102,0,24'h1008,1);

        do_reset();
        fb_base = 24'h1000;
        for (int i = 0; i < tbl.size(); i++) begin
            ce = tbl[i].ce; vsync = tbl[i].vs; req = tbl[i].rq;
            mem.mem_ack = tbl[i].ack; mem.mem_rvalid = tbl[i].rv;
            mem.mem_rdata = tbl[i].rd;
            cyc();
            check($sformatf("vec%0d_level", i), fifo_level, tbl[i].lvl);
            check($sformatf("vec%0d_viddata", i), viddata, tbl[i].vd);
            check($sformatf("vec%0d_memreq", i), mem.mem_req, tbl[i].mr);
            check($sformatf("vec%0d_memaddr", i), mem.mem_addr, tbl[i].ma);
            check($sformatf("vec%0d_underrun", i), underrun, tbl[i].ur);
        end
        ce = 1'b1; req = 1'b0; mem.mem_ack = 1'b0; mem.mem_rvalid = 1'b0;

        // Throttle: requests stop at a full FIFO, resume at 56
        do_reset();
        fb_base = 24'h1000; exp_addr = 24'h1000; mem_auto = 1;
        pulse_vsync();
        repeat (150) cyc();
        check("full_level", fifo_level, 64);
        check("full_bursts", nbursts, 8);
        check("full_memreq", mem.mem_req, 0);
        req = 1'b1;
        repeat (7) cyc();
        req = 1'b0;
        repeat (4) cyc();
        check("thr_level57", fifo_level, 57);
        check("thr_memreq57", mem.mem_req, 0);
        req = 1'b1; cyc(); req = 1'b0;
        check("thr_level56", fifo_level, 56);
        check("thr_memreq56a", mem.mem_req, 0);
        cyc();
        check("thr_memreq56b", mem.mem_req, 1);
        check("thr_memaddr", mem.mem_addr, 24'h1040);

        // Whole (reduced) frame, req every second cycle
        do_reset();
        fb_base = 24'h1000; exp_addr = 24'h1000; mem_auto = 1; sb_on = 1;
        pulse_vsync();
        popped = 0; k = 0;
        while (popped < FW && k < 20000) begin
            req = 1'b0;
            if ((k % 2) == 1 && fifo_level != 0 && sb.size() != 0) begin
                req = 1'b1;
                check("frame_pixel", viddata, sb.pop_front());
                popped++;
            end
            cyc();
            k++;
        end
        req = 1'b0;
        check("frame_popped", popped, FW);
        check("frame_bursts", nbursts, FW / BL);
        check("frame_lastaddr", last_addr, 24'h1000 + 24'(FW - BL));
        check("frame_underrun", underrun, 0);
        repeat (40) cyc();
        check("done_bursts", nbursts, FW / BL);
        check("done_memreq", mem.mem_req, 0);
        check("done_level", fifo_level, 0);

        // Pop while empty, memory never answers
        do_reset();
        fb_base = 24'h0800;
        pulse_vsync();
        repeat (3) cyc();
        check("empty_memreq", mem.mem_req, 1);
        req = 1'b1; cyc(); req = 1'b0;
        check("empty_underrun", underrun, 1);
        check("empty_viddata", viddata, 0);
        check("empty_level", fifo_level, 0);

        // Restart during DATA after 3 beats, then during REQ
        do_reset();
        fb_base = 24'h2000;
        pulse_vsync();
        check("rs_memreq0", mem.mem_req, 1);
        check("rs_memaddr0", mem.mem_addr, 24'h2000);
        mem.mem_ack = 1'b1; cyc(); mem.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'(i); cyc();
        end
        mem.mem_rvalid = 1'b0;
        check("rs_level3", fifo_level, 3);
        fb_base = 24'h3000; vsync = 1'b1; cyc(); vsync = 1'b0;
        check("rs_flush", fifo_level, 0);
        for (int i = 0; i < 5; i++) begin
            mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'(50 + i); cyc();
            check("rs_drain_level", fifo_level, 0);
            check("rs_drain_memreq", mem.mem_req, 0);
        end
        mem.mem_rvalid = 1'b0;
        cyc();
        check("rs_memreq1", mem.mem_req, 1);
        check("rs_memaddr1", mem.mem_addr, 24'h3000);
        fb_base = 24'h4000; vsync = 1'b1; cyc(); vsync = 1'b0;
        check("rq_hold_req", mem.mem_req, 1);
        check("rq_hold_addr", mem.mem_addr, 24'h3000);
        mem.mem_ack = 1'b1; cyc(); mem.mem_ack = 1'b0;
        check("rq_ack_memreq", mem.mem_req, 0);
        for (int i = 0; i < BL; i++) begin
            mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'(70 + i); cyc();
            check("rq_drain_level", fifo_level, 0);
        end
        mem.mem_rvalid = 1'b0;
        cyc();
        check("rq_memreq2", mem.mem_req, 1);
        check("rq_memaddr2", mem.mem_addr, 24'h4000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
